// File: rtl/fifo_pkg.sv
// Shared constants and elaboration-time helpers for the synchronous FIFO.
// Other FIFO files import this package.
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 32;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Legal parameter set: power-of-two depth >= 2, thresholds within range.
    function automatic bit params_ok(input int width, input int depth,
                                     input int af, input int ae, input int show_ahead);
        return (width >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
               (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1) &&
               (show_ahead == 0 || show_ahead == 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// Contents are never reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    localparam int AW        = clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller: wrap-bit pointers, registered status flags,
// sticky error flags, and either a registered or show-ahead read port.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int SHOW_AHEAD = 0,
    localparam int AW        = clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [AW:0]           count,
    output logic                  overflow,
    output logic                  underflow
);

    if (!params_ok(DATA_WIDTH, DEPTH, AF_THRESH, AE_THRESH, SHOW_AHEAD)) begin : g_bad_params
        $error("sync_fifo_ctrl: illegal DATA_WIDTH/DEPTH/threshold/SHOW_AHEAD combination");
    end

    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
    localparam logic [AW:0] AF_C    = AF_THRESH[AW:0];
    localparam logic [AW:0] AE_C    = AE_THRESH[AW:0];

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic        full_q, full_d;
    logic        empty_q, empty_d;
    logic        almost_full_q, almost_full_d;
    logic        almost_empty_q, almost_empty_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;
    logic        wr_accept, rd_accept;
    logic [DATA_WIDTH-1:0] ram_rdata;

    always_comb begin
        // flush masks both requests, so it can neither move data nor raise errors
        rd_accept = rd_en & ~empty_q & ~flush;
        wr_accept = wr_en & ~flush & (~full_q | rd_accept);

        wr_ptr_d = flush ? '0 : wr_ptr_q + {{AW{1'b0}}, wr_accept};
        rd_ptr_d = flush ? '0 : rd_ptr_q + {{AW{1'b0}}, rd_accept};
        // Pointer difference with wrap bit equals count + wr_accept - rd_accept.
        count_d  = wr_ptr_d - rd_ptr_d;

        full_d         = (count_d == DEPTH_C);
        empty_d        = (count_d == '0);
        almost_full_d  = (count_d >= AF_C);
        almost_empty_d = (count_d <= AE_C);

        overflow_d  = (overflow_q & ~clr_err) | (wr_en & ~flush & ~wr_accept);
        underflow_d = (underflow_q & ~clr_err) | (rd_en & ~flush & empty_q);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clock   (clock),
        .we_i    (wr_accept & reset),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    if (SHOW_AHEAD != 0) begin : g_show_ahead
        // Head word is presented directly; gated to zero while empty.
        assign rd_data  = empty_q ? '0 : ram_rdata;
        assign rd_valid = ~empty_q;
    end else begin : g_registered
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_valid_q;

        always_ff @(posedge clock) begin
            if (!reset) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_accept;
                if (rd_accept) begin
                    rd_data_q <= ram_rdata;
                end
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench: a vector table drives a DEPTH=32 registered-read FIFO,
// followed by hand sequences for reset mid-stream and a small show-ahead FIFO.
module tb_sync_fifo_ctrl;

    localparam int AF0 = 30;
    localparam int AE0 = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    // Registered-read instance (defaults)
    logic       flush0 = 0, clr0 = 0, we0 = 0, re0 = 0;
    logic [7:0] wd0 = 0;
    logic [7:0] rd0;
    logic       rv0, full0, empty0, af0, ae0, ovf0, unf0;
    logic [5:0] cnt0;

    // Show-ahead instance
    logic       flush1 = 0, clr1 = 0, we1 = 0, re1 = 0;
    logic [7:0] wd1 = 0;
    logic [7:0] rd1;
    logic       rv1, full1, empty1, af1, ae1, ovf1, unf1;
    logic [2:0] cnt1;

    sync_fifo_ctrl #(
        .DATA_WIDTH (8), .DEPTH (32), .AF_THRESH (AF0), .AE_THRESH (AE0), .SHOW_AHEAD (0)
    ) dut0 (
        .clock (clock), .reset (reset), .flush (flush0), .clr_err (clr0),
        .wr_en (we0), .wr_data (wd0), .rd_en (re0),
        .rd_data (rd0), .rd_valid (rv0), .full (full0), .empty (empty0),
        .almost_full (af0), .almost_empty (ae0), .count (cnt0),
        .overflow (ovf0), .underflow (unf0)
    );

    sync_fifo_ctrl #(
        .DATA_WIDTH (8), .DEPTH (4), .AF_THRESH (2), .AE_THRESH (1), .SHOW_AHEAD (1)
    ) dut1 (
        .clock (clock), .reset (reset), .flush (flush1), .clr_err (clr1),
        .wr_en (we1), .wr_data (wd1), .rd_en (re1),
        .rd_data (rd1), .rd_valid (rv1), .full (full1), .empty (empty1),
        .almost_full (af1), .almost_empty (ae1), .count (cnt1),
        .overflow (ovf1), .underflow (unf1)
    );

    typedef struct {
        logic       fl, ce, we, re;
        logic [7:0] wd;
        int         cnt;
        logic       rv, chk_rd;
        logic [7:0] rd;
        logic       ovf, unf;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic void add(input logic fl, input logic ce, input logic we,
                                input logic [7:0] wd, input logic re, input int cnt,
                                input logic rv, input logic chk_rd, input logic [7:0] rd,
                                input logic ovf, input logic unf);
        vec_t v;
        v.fl = fl; v.ce = ce; v.we = we; v.wd = wd; v.re = re; v.cnt = cnt;
        v.rv = rv; v.chk_rd = chk_rd; v.rd = rd; v.ovf = ovf; v.unf = unf;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- vector table for dut0 ----------------
        for (int i = 0; i < 32; i++) add(0, 0, 1, i[7:0], 0, i + 1, 0, 0, 8'h00, 0, 0);
        add(0, 0, 1, 8'hEE, 0, 32, 0, 0, 8'h00, 1, 0);                     // 33rd write overflows
        for (int i = 0; i < 32; i++) add(0, 0, 0, 8'h00, 1, 31 - i, 1, 1, i[7:0], 1, 0);
        add(0, 0, 0, 8'h00, 1, 0, 0, 1, 8'h1F, 1, 1);                      // extra read underflows
        add(0, 1, 0, 8'h00, 1, 0, 0, 1, 8'h1F, 0, 1);                      // clr_err loses to new event
        add(0, 1, 0, 8'h00, 0, 0, 0, 1, 8'h1F, 0, 0);
        // wrap-around
        for (int i = 0; i < 20; i++) add(0, 0, 1, 8'h40 + i[7:0], 0, i + 1, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 20; i++) add(0, 0, 0, 8'h00, 1, 19 - i, 1, 1, 8'h40 + i[7:0], 0, 0);
        for (int i = 0; i < 20; i++) add(0, 0, 1, 8'hA0 + i[7:0], 0, i + 1, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 20; i++) add(0, 0, 0, 8'h00, 1, 19 - i, 1, 1, 8'hA0 + i[7:0], 0, 0);
        // full plus simultaneous read/write
        for (int i = 0; i < 32; i++) add(0, 0, 1, 8'h60 + i[7:0], 0, i + 1, 0, 0, 8'h00, 0, 0);
        add(0, 0, 1, 8'h55, 1, 32, 1, 1, 8'h60, 0, 0);
        for (int i = 0; i < 32; i++)
            add(0, 0, 0, 8'h00, 1, 31 - i, 1, 1, (i < 31) ? 8'h61 + i[7:0] : 8'h55, 0, 0);
        // flush
        add(0, 0, 0, 8'h00, 1, 0, 0, 1, 8'h55, 0, 1);
        for (int i = 0; i < 10; i++) add(0, 0, 1, 8'h80 + i[7:0], 0, i + 1, 0, 0, 8'h00, 0, 1);
        add(1, 0, 1, 8'h99, 1, 0, 0, 0, 8'h00, 0, 1);
        add(0, 0, 1, 8'h3C, 0, 1, 0, 0, 8'h00, 0, 1);
        add(0, 0, 0, 8'h00, 1, 0, 1, 1, 8'h3C, 0, 1);

        // ---------------- reset state ----------------
        reset = 1'b0;
        tick();
        tick();
        $display("reset: count=%0d empty=%0b rd_valid=%0b rd_data=%02h", cnt0, empty0, rv0, rd0);
        chk("rst_count", 0, cnt0, 0);
        chk("rst_empty", 0, empty0, 1);
        chk("rst_ae", 0, ae0, 1);
        chk("rst_full", 0, full0, 0);
        chk("rst_af", 0, af0, 0);
        chk("rst_ovf", 0, ovf0, 0);
        chk("rst_unf", 0, unf0, 0);
        chk("rst_rv", 0, rv0, 0);
        chk("rst_rd", 0, rd0, 0);
        chk("rst_rv_sa", 0, rv1, 0);
        chk("rst_rd_sa", 0, rd1, 0);
        reset = 1'b1;

        // ---------------- apply table ----------------
        for (int k = 0; k < vecs.size(); k++) begin
            flush0 = vecs[k].fl; clr0 = vecs[k].ce; we0 = vecs[k].we;
            wd0 = vecs[k].wd; re0 = vecs[k].re;
            tick();
            $display("vec %0d: fl=%0b ce=%0b we=%0b wd=%02h re=%0b -> count=%0d rv=%0b rd=%02h ovf=%0b unf=%0b",
                     k, vecs[k].fl, vecs[k].ce, vecs[k].we, vecs[k].wd, vecs[k].re,
                     cnt0, rv0, rd0, ovf0, unf0);
            chk("count", k, cnt0, vecs[k].cnt);
            chk("empty", k, empty0, (vecs[k].cnt == 0));
            chk("full", k, full0, (vecs[k].cnt == 32));
            chk("almost_full", k, af0, (vecs[k].cnt >= AF0));
            chk("almost_empty", k, ae0, (vecs[k].cnt <= AE0));
            chk("rd_valid", k, rv0, vecs[k].rv);
            chk("overflow", k, ovf0, vecs[k].ovf);
            chk("underflow", k, unf0, vecs[k].unf);
            if (vecs[k].chk_rd) chk("rd_data", k, rd0, vecs[k].rd);
        end
        flush0 = 0; clr0 = 0; we0 = 0; re0 = 0;

        // ---------------- mid-stream reset, registered mode ----------------
        we0 = 1;
        for (int i = 0; i < 3; i++) begin
            wd0 = 8'h10 + i[7:0];
            tick();
        end
        $display("pre-reset fill: count=%0d", cnt0);
        chk("mid_fill_count", 1, cnt0, 3);
        reset = 1'b0;
        wd0 = 8'hEE;
        tick();
        $display("mid reset: count=%0d empty=%0b rv=%0b rd=%02h unf=%0b", cnt0, empty0, rv0, rd0, unf0);
        chk("mid_rst_count", 1, cnt0, 0);
        chk("mid_rst_empty", 1, empty0, 1);
        chk("mid_rst_rv", 1, rv0, 0);
        chk("mid_rst_rd", 1, rd0, 0);
        chk("mid_rst_unf", 1, unf0, 0);
        reset = 1'b1;
        wd0 = 8'h77;
        tick();
        $display("post-reset write 77: count=%0d", cnt0);
        chk("post_rst_count", 1, cnt0, 1);
        chk("post_rst_empty", 1, empty0, 0);
        we0 = 0; re0 = 1;
        tick();
        $display("post-reset read: rv=%0b rd=%02h count=%0d", rv0, rd0, cnt0);
        chk("post_rst_rv", 1, rv0, 1);
        chk("post_rst_rd", 1, rd0, 8'h77);
        chk("post_rst_empty2", 1, empty0, 1);
        re0 = 0;

        // ---------------- show-ahead instance ----------------
        reset = 1'b0;
        tick();
        reset = 1'b1;
        we1 = 1; wd1 = 8'h11;
        tick();
        $display("sa write 11: count=%0d rv=%0b rd=%02h ae=%0b", cnt1, rv1, rd1, ae1);
        chk("sa_rd_11", 2, rd1, 8'h11);
        chk("sa_rv_11", 2, rv1, 1);
        chk("sa_ae_1", 2, ae1, 1);
        wd1 = 8'h22;
        tick();
        $display("sa write 22: count=%0d rd=%02h ae=%0b af=%0b", cnt1, rd1, ae1, af1);
        chk("sa_ae_2", 2, ae1, 0);
        chk("sa_af_2", 2, af1, 1);
        chk("sa_head_11", 2, rd1, 8'h11);
        we1 = 0; re1 = 1;
        tick();
        $display("sa pop: count=%0d rd=%02h", cnt1, rd1);
        chk("sa_pop_rd", 2, rd1, 8'h22);
        chk("sa_pop_count", 2, cnt1, 1);
        we1 = 1; wd1 = 8'h33;
        tick();
        $display("sa pop+push 33: count=%0d rd=%02h", cnt1, rd1);
        chk("sa_rw_rd", 2, rd1, 8'h33);
        chk("sa_rw_count", 2, cnt1, 1);
        re1 = 0;
        for (int i = 0; i < 3; i++) begin
            wd1 = 8'h44 + i[7:0];
            tick();
        end
        $display("sa fill: count=%0d full=%0b rd=%02h", cnt1, full1, rd1);
        chk("sa_full", 2, full1, 1);
        chk("sa_full_count", 2, cnt1, 4);
        chk("sa_full_head", 2, rd1, 8'h33);
        wd1 = 8'h77;
        tick();
        $display("sa write when full: count=%0d ovf=%0b", cnt1, ovf1);
        chk("sa_ovf", 2, ovf1, 1);
        chk("sa_ovf_count", 2, cnt1, 4);
        we1 = 0;
        reset = 1'b0;
        tick();
        $display("sa mid reset: count=%0d rv=%0b rd=%02h", cnt1, rv1, rd1);
        chk("sa_rst_count", 2, cnt1, 0);
        chk("sa_rst_rv", 2, rv1, 0);
        chk("sa_rst_rd", 2, rd1, 0);
        chk("sa_rst_ovf", 2, ovf1, 0);
        reset = 1'b1;
        re1 = 1;
        tick();
        $display("sa read on empty: unf=%0b rv=%0b", unf1, rv1);
        chk("sa_unf", 2, unf1, 1);
        chk("sa_unf_rv", 2, rv1, 0);
        re1 = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
